axi4_mem_arbiter: RTL and testbench
===================================

Name: axi4_mem_arbiter

Overview:
- Shares one single-port on-chip memory (1-cycle registered read) between NUM_REQ word-addressed requesters, e.g. the AXI4 slave write path, read path and a debug/DMA port.
- Sits between the AXI4 slave front-ends and the memory model.
- Round-robin grant per beat, with an optional burst lock.
- Routes read data back to the requester that issued the read.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_WIDTH, 32, memory data width
MEMORY_DEPTH, 1024, memory words; MA = $clog2(MEMORY_DEPTH)
MAX_LOCK_BEATS, 16, maximum consecutive beats one locked requester may hold the grant

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_ready  out  NUM_REQ  per-requester beat accepted
req_we  in  NUM_REQ  1=write, 0=read
req_lock  in  NUM_REQ  keep grant after this beat (burst)
req_addr  in  NUM_REQ*MA  word address, requester i at [i*MA +: MA]
req_wdata  in  NUM_REQ*DATA_WIDTH  write data, same slicing
rsp_valid  out  NUM_REQ  one-cycle pulse, read data valid for requester i
rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters, qualified by rsp_valid
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  MA  memory word address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_en && !mem_we
grant_id  out  $clog2(NUM_REQ)  current or last grantee, for debug/coverage

Behaviour:
- One clock ACLK; reset ARESETn is asynchronous, active-low.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
  - grant_id=0, rr pointer=0, lock counter=0, FSM=ARB_IDLE, response pipeline cleared.
- Arbitration is combinational each cycle.
  - Winner = first requester with req_valid, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[winner]=1, all others 0. At most one ready bit is set per cycle.
  - Accept = req_valid && req_ready in cycle t.
- Memory side is registered:
  - On accept at t: mem_en=1, mem_we=req_we, mem_addr and mem_wdata take the winner's fields at t+1.
  - With no accept at t: mem_en=0 and mem_we=0 at t+1; addr and wdata hold.
- Read response:
  - A read accepted at t raises rsp_valid[winner] at t+2, with rsp_rdata=mem_rdata.
  - Owner id is carried in a 2-deep shift register.
  - Throughput is 1 beat per cycle, with back-to-back reads from different requesters.
  - No backpressure on the response; requesters must sink it.
- rr_ptr update: after an unlocked accept, rr_ptr = winner+1 (mod NUM_REQ).
- FSM:
  - ARB_IDLE: free arbitration.
    - Accept with req_lock=1 (and lock enabled) -> ARB_LOCKED, lock_cnt=1, owner=winner.
  - ARB_LOCKED: only the owner is eligible; other requesters wait even if valid.
    - Each owner accept increments lock_cnt.
    - Return to ARB_IDLE when the owner is accepted with req_lock=0, or when lock_cnt reaches MAX_LOCK_BEATS (forced release).
    - On exit, rr_ptr=owner+1.
    - Owner req_valid=0 while locked: hold grant and wait; no timeout on idle cycles.
- Boundary conditions:
  - No requester valid: all req_ready=0 and rr_ptr unchanged.
  - Single valid requester: always granted, at one beat per cycle.
  - Out-of-range addresses cannot occur, since req_addr is already MA wide. Range checking belongs to the front-end.
  - Reset mid-burst: asynchronous clear to ARB_IDLE; pending rsp_valid pulses are dropped.

Optional Feature:
- Macro: AXI4_MEM_ARB_LOCK_EN.
- Defined: req_lock is honoured; ARB_LOCKED and lock_cnt exist as described.
- Undefined: req_lock is ignored and the FSM stays in ARB_IDLE. Round-robin is applied every beat, so bursts from different requesters interleave.

Decomposition:
- Package axi4_mem_pkg holds:
  - arb_state_e (ARB_IDLE, ARB_LOCKED)
  - localparams for default DATA_WIDTH, MEMORY_DEPTH, MAX_LOCK_BEATS
  - the MA-width function or typedef mem_addr_t.
- Sub-module rr_arbiter (combinational): inputs req and ptr, outputs one-hot grant plus index. It is reused by the read/write channel muxes.

Test Plan:
- Reset then idle -> all outputs 0, mem_en stays 0 for 10 cycles.
- Req0 writes addr 5, data 0xDEADBEEF; at t+2 req1 reads addr 5 -> at t+1 mem_en=1, mem_we=1, mem_addr=5. rsp_valid[1] is high 2 cycles after the read accept, with rsp_rdata=0xDEADBEEF; rsp_valid[0] never asserts.
- Both requesters hold valid for 6 cycles, no lock -> accepts alternate 0,1,0,1,0,1 and grant_id toggles.
- With lock: req0 issues 4-beat write (lock=1,1,1,0) while req1 is valid -> req1 is not ready until after beat 4, then granted the next cycle.
- With lock: req0 holds lock=1 for 20 beats -> forced release after 16 beats, req1 granted at beat 17, rr_ptr=1.
- ARESETn asserted mid-burst with a read in flight -> immediate clear of state; no rsp_valid after release; the first post-reset accept is requester 0.

Source files
------------

// File: rtl/axi4_mem_pkg.sv
// -----------------------------------------------------------------------------
// axi4_mem_pkg
// Shared types and defaults for the single-port memory arbiter.
//   - arb_state_e : arbiter FSM state (free round-robin / burst-locked)
//   - DEF_*       : default parameter values used by axi4_mem_arbiter
//   - addr_width  : word-address width for a given memory depth
// -----------------------------------------------------------------------------
package axi4_mem_pkg;

   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_MEMORY_DEPTH   = 1024;
   localparam int DEF_MAX_LOCK_BEATS = 16;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // Depth 1 still needs a 1-bit address bus.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/axi4_mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: the first set bit of req_i, searching
// upward from ptr_i and wrapping modulo N.
//   req_i   in  N   request vector
//   ptr_i   in  IW  search start index (0..N-1)
//   grant_o out N   one-hot grant (all zero when no request)
//   idx_o   out IW  index of the granted request
//   valid_o out 1   some request was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   always_comb begin
      // NOTE: every output gets a default before the search loop so no path
      // leaves it unassigned, which would infer a latch.
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!valid_o && req_i[(int'(ptr_i) + k) % N]) begin
            valid_o                           = 1'b1;
            idx_o                             = IW'((int'(ptr_i) + k) % N);
            grant_o[(int'(ptr_i) + k) % N]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi4_mem_arbiter.sv
// -----------------------------------------------------------------------------
// axi4_mem_arbiter
// Shares one single-port memory (1-cycle registered read) between NUM_REQ
// word-addressed requesters. One beat is granted per cycle by round-robin;
// read data is routed back to the requester that issued the read, two
// cycles after its accept.
//
// Build option: define AXI4_MEM_ARB_LOCK_EN to honour req_lock (burst lock,
// capped at MAX_LOCK_BEATS consecutive beats). Without it req_lock is ignored
// and every beat is arbitrated afresh.
//
// Ports
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester beat handshake
//   req_we, req_lock       per-requester write flag, keep-grant flag
//   req_addr, req_wdata    requester i at [i*MA +: MA] / [i*DATA_WIDTH +: ...]
//   rsp_valid              one-cycle read-data pulse, one bit per requester
//   rsp_rdata              shared read data, zero unless rsp_valid is set
//   mem_en/we/addr/wdata   registered memory command
//   mem_rdata              memory read data (cycle after a read command)
//   grant_id               last accepted requester
// -----------------------------------------------------------------------------
module axi4_mem_arbiter
   import axi4_mem_pkg::*;
#(
   parameter  int NUM_REQ        = 2,
   parameter  int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter  int MEMORY_DEPTH   = DEF_MEMORY_DEPTH,
   parameter  int MAX_LOCK_BEATS = DEF_MAX_LOCK_BEATS,
   localparam int MA             = addr_width(MEMORY_DEPTH),
   localparam int GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          ACLK,
   input  logic                          ARESETn,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ-1:0]            req_lock,
   input  logic [NUM_REQ*MA-1:0]         req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [MA-1:0]                 mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   input  logic [DATA_WIDTH-1:0]         mem_rdata,
   output logic [GW-1:0]                 grant_id
);

   localparam int CW = $clog2(MAX_LOCK_BEATS + 1);

   function automatic logic [NUM_REQ-1:0] to_onehot(input logic [GW-1:0] id);
      to_onehot     = '0;
      to_onehot[id] = 1'b1;
   endfunction

   function automatic logic [GW-1:0] ptr_after(input logic [GW-1:0] idx);
      return (int'(idx) == NUM_REQ - 1) ? '0 : GW'(int'(idx) + 1);
   endfunction

   logic [NUM_REQ-1:0]    eligible;
   logic [NUM_REQ-1:0]    gnt_oh;
   logic [GW-1:0]         gnt_idx;
   logic                  gnt_any;
   logic [GW-1:0]         rr_ptr_q, rr_ptr_d;

   logic                  mem_en_q, mem_we_q;
   logic [MA-1:0]         mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [GW-1:0]         grant_id_q;

   // Read-owner pipeline: stage 0 lines up with the memory command, stage 1
   // with the memory read data.
   logic                  rd_v0_q, rd_v1_q;
   logic [GW-1:0]         rd_id0_q, rd_id1_q;

   rr_arbiter #(.N(NUM_REQ), .IW(GW)) u_rr (
      .req_i   (eligible),
      .ptr_i   (rr_ptr_q),
      .grant_o (gnt_oh),
      .idx_o   (gnt_idx),
      .valid_o (gnt_any)
   );

   // Ready goes only to a valid winner, so a grant is always an accept.
   assign req_ready = gnt_oh;

`ifdef AXI4_MEM_ARB_LOCK_EN
   arb_state_e    state_q, state_d;
   logic [GW-1:0] owner_q, owner_d;
   logic [CW-1:0] lock_cnt_q, lock_cnt_d;

   // While locked only the owner may compete; an idle owner keeps the grant.
   assign eligible = (state_q == ARB_LOCKED) ? (req_valid & to_onehot(owner_q))
                                             : req_valid;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      if (gnt_any) begin
         case (state_q)
            ARB_IDLE: begin
               // A cap of one beat means a lock can never extend the grant.
               if (req_lock[gnt_idx] && (MAX_LOCK_BEATS > 1)) begin
                  state_d    = ARB_LOCKED;
                  owner_d    = gnt_idx;
                  lock_cnt_d = CW'(1);
               end else begin
                  rr_ptr_d = ptr_after(gnt_idx);
               end
            end
            ARB_LOCKED: begin
               // Release on the beat that drops lock or that reaches the cap.
               if (!req_lock[gnt_idx] || (int'(lock_cnt_q) + 1 >= MAX_LOCK_BEATS)) begin
                  state_d    = ARB_IDLE;
                  lock_cnt_d = '0;
                  rr_ptr_d   = ptr_after(owner_q);
               end else begin
                  lock_cnt_d = lock_cnt_q + 1'b1;
               end
            end
            default: state_d = ARB_IDLE;
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q    <= ARB_IDLE;
         owner_q    <= '0;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end
`else
   logic unused_lock;
   assign unused_lock = ^req_lock;
   assign eligible    = req_valid;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_any) rr_ptr_d = ptr_after(gnt_idx);
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         rr_ptr_q    <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         grant_id_q  <= '0;
         // Clearing the owner pipeline drops responses still in flight.
         rd_v0_q     <= 1'b0;
         rd_v1_q     <= 1'b0;
         rd_id0_q    <= '0;
         rd_id1_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         mem_en_q <= gnt_any;
         mem_we_q <= gnt_any & req_we[gnt_idx];
         if (gnt_any) begin
            mem_addr_q  <= req_addr[int'(gnt_idx)*MA +: MA];
            mem_wdata_q <= req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            grant_id_q  <= gnt_idx;
         end
         rd_v0_q  <= gnt_any & ~req_we[gnt_idx];
         rd_id0_q <= gnt_idx;
         rd_v1_q  <= rd_v0_q;
         rd_id1_q <= rd_id0_q;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign grant_id  = grant_id_q;
   assign rsp_valid = rd_v1_q ? to_onehot(rd_id1_q) : '0;
   assign rsp_rdata = rd_v1_q ? mem_rdata : '0;

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi4_mem_arbiter
// Directed bench for axi4_mem_arbiter (NUM_REQ=2, defaults otherwise) with a
// small single-port memory model. Expected values follow the build option
// AXI4_MEM_ARB_LOCK_EN: with it, bursts hold the grant; without it, every
// beat is round-robin.
// -----------------------------------------------------------------------------
module tb_axi4_mem_arbiter;

   localparam int NR = 2;
   localparam int DW = 32;
   localparam int MA = 10;
`ifdef AXI4_MEM_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic             ACLK = 1'b0;
   logic             ARESETn;
   logic [NR-1:0]    req_valid, req_ready, req_we, req_lock, rsp_valid;
   logic [NR*MA-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata;
   logic [DW-1:0]    rsp_rdata, mem_wdata;
   logic [DW-1:0]    mem_rdata = '0;
   logic             mem_en, mem_we;
   logic [MA-1:0]    mem_addr;
   logic [0:0]       grant_id;

   logic [DW-1:0]    mem_model [1024];

   int n_checks = 0;
   int n_fail   = 0;

   axi4_mem_arbiter #(.NUM_REQ(NR)) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_lock  (req_lock),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .grant_id  (grant_id)
   );

   always #5 ACLK = ~ACLK;

   // Single-port memory with a registered read port.
   always @(posedge ACLK) begin
      if (mem_en) begin
         if (mem_we) mem_model[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem_model[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int r, input logic v, input logic we, input logic lk,
                        input logic [MA-1:0] a, input logic [DW-1:0] d);
      req_valid[r]           = v;
      req_we[r]              = we;
      req_lock[r]            = lk;
      req_addr[r*MA +: MA]   = a;
      req_wdata[r*DW +: DW]  = d;
   endtask

   task automatic clear_req();
      req_valid = '0;
      req_we    = '0;
      req_lock  = '0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   task automatic next_cycle();
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_reset();
      clear_req();
      ARESETn = 1'b0;
      repeat (2) @(posedge ACLK);
      #1 ARESETn = 1'b1;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_ready"},     req_ready, 0);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 0);
      check({tag, "_mem_en"},    mem_en,    0);
      check({tag, "_mem_we"},    mem_we,    0);
      check({tag, "_mem_addr"},  mem_addr,  0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_grant_id"},  grant_id,  0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [4:0] t_r0v, t_r0lk, t_r1v;
      logic [9:0] t_exp;
      int         grant_k;

      // ---------------- reset and idle ----------------
      ARESETn = 1'b0;
      clear_req();
      #12;
      check_cleared("reset");
      next_cycle();
      ARESETn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge ACLK);
         check("idle_mem_en", mem_en, 0);
         check("idle_ready", req_ready, 0);
         next_cycle();
      end

      // ---------------- write then read-back ----------------
      drive(0, 1'b1, 1'b1, 1'b0, 10'd5, 32'hDEADBEEF);
      @(negedge ACLK);
      check("wr_ready", req_ready, 2'b01);
      next_cycle();
      clear_req();
      @(negedge ACLK);
      check("wr_mem_en", mem_en, 1);
      check("wr_mem_we", mem_we, 1);
      check("wr_mem_addr", mem_addr, 5);
      check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
      check("wr_grant_id", grant_id, 0);
      check("wr_no_ready", req_ready, 0);
      next_cycle();
      drive(1, 1'b1, 1'b0, 1'b0, 10'd5, 32'h0);
      @(negedge ACLK);
      check("rd_ready", req_ready, 2'b10);
      check("wr_no_rsp", rsp_valid, 0);
      next_cycle();
      clear_req();
      @(negedge ACLK);
      check("rd_mem_en", mem_en, 1);
      check("rd_mem_we", mem_we, 0);
      check("rd_mem_addr", mem_addr, 5);
      check("rd_rsp_early", rsp_valid, 0);
      next_cycle();
      @(negedge ACLK);
      check("rd_rsp_valid", rsp_valid, 2'b10);
      check("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      next_cycle();
      @(negedge ACLK);
      check("rd_rsp_done", rsp_valid, 0);
      next_cycle();

      // ---------------- both valid, round-robin reads ----------------
      for (int k = 0; k < 6; k++) begin
         drive(0, 1'b1, 1'b0, 1'b0, 10'd5, 32'h0);
         drive(1, 1'b1, 1'b0, 1'b0, 10'd5, 32'h0);
         @(negedge ACLK);
         check("rr_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         if (k >= 1) check("rr_grant_id", grant_id, (k - 1) % 2);
         if (k >= 2) begin
            check("rr_rsp_valid", rsp_valid, ((k - 2) % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
         end
         next_cycle();
      end
      clear_req();
      @(negedge ACLK);
      check("rr_tail_rsp0", rsp_valid, 2'b01);
      next_cycle();
      @(negedge ACLK);
      check("rr_tail_rsp1", rsp_valid, 2'b10);
      next_cycle();
      @(negedge ACLK);
      check("rr_tail_none", rsp_valid, 0);
      next_cycle();

      // ---------------- 4-beat burst from req0 vs req1 ----------------
      // Bit k of each table is cycle k; t_exp holds 2-bit ready per cycle.
      t_r0v  = LOCK_EN ? 5'b01111 : 5'b11111;
      t_r0lk = LOCK_EN ? 5'b00111 : 5'b01111;
      t_r1v  = LOCK_EN ? 5'b11111 : 5'b00011;
      t_exp  = LOCK_EN ? 10'b10_01_01_01_01 : 10'b01_01_01_10_01;
      for (int k = 0; k < 5; k++) begin
         drive(0, t_r0v[k], 1'b1, t_r0lk[k], MA'(20 + k), DW'(k));
         drive(1, t_r1v[k], 1'b1, 1'b0, 10'd30, 32'h1111);
         @(negedge ACLK);
         check("burst4_ready", req_ready, t_exp[2*k +: 2]);
         next_cycle();
      end
      clear_req();
      @(negedge ACLK);
      check("burst4_last_grant", grant_id, LOCK_EN ? 1 : 0);
      next_cycle();

      // ---------------- long lock, forced release ----------------
      do_reset();
      grant_k = LOCK_EN ? 16 : 1;
      for (int k = 0; k < 18; k++) begin
         drive(0, 1'b1, 1'b1, 1'b1, MA'(40 + k), DW'(k));
         drive(1, (k <= grant_k), 1'b1, 1'b0, 10'd60, 32'h2222);
         @(negedge ACLK);
         check("lock20_ready", req_ready, (k == grant_k) ? 2'b10 : 2'b01);
         if (k >= 1) check("lock20_grant_id", grant_id, (k - 1 == grant_k) ? 1 : 0);
         next_cycle();
      end
      clear_req();

      // ---------------- reset mid-burst with reads in flight ----------------
      for (int k = 0; k < 2; k++) begin
         drive(0, 1'b1, 1'b0, 1'b1, 10'd5, 32'h0);
         @(negedge ACLK);
         check("midrst_pre_ready", req_ready, 2'b01);
         next_cycle();
      end
      clear_req();
      ARESETn = 1'b0;
      #1;
      check_cleared("midrst");
      repeat (2) @(posedge ACLK);
      #1 ARESETn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge ACLK);
         check("midrst_no_rsp", rsp_valid, 0);
         check("midrst_no_mem_en", mem_en, 0);
         next_cycle();
      end
      drive(0, 1'b1, 1'b0, 1'b0, 10'd5, 32'h0);
      drive(1, 1'b1, 1'b0, 1'b0, 10'd5, 32'h0);
      @(negedge ACLK);
      check("postrst_ready", req_ready, 2'b01);
      next_cycle();
      clear_req();
      @(negedge ACLK);
      check("postrst_grant_id", grant_id, 0);
      check("postrst_mem_en", mem_en, 1);
      next_cycle();
      @(negedge ACLK);
      check("postrst_rsp_valid", rsp_valid, 2'b01);
      check("postrst_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
